// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types, defaults and the sum helper for the shared-adder arbiter.
package adder_arb_pkg;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    localparam int DEF_N_REQ = 4;
    localparam int IDX_W = $clog2(DEF_N_REQ);
    localparam int MAX_W = 32;
    // Callers cast the result down to W+1 bits, keeping the carry in bit W.
    function automatic logic [MAX_W:0] zext_sum(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);
    logic found;
    always_comb begin
        gnt = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (en && !found && req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
                idx = IDX_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one registered W-bit adder among N_REQ requesters.
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W:0]         rsp_sum,
    output logic               busy
);
    localparam int IW = $clog2(N_REQ);
    state_t state_q, state_d;
    logic [IW-1:0] ptr_q, win_q, idx;
    logic [N_REQ-1:0] gnt;
    logic [W-1:0] a_q, b_q;
    logic [W:0] sum_q;
    logic en;
    // Gating on rst keeps req_ready low while reset is held, not just after the next edge.
    assign en = (state_q == IDLE) && !rst;
    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IW)) u_arb (
        .req(req_valid),
        .ptr(ptr_q),
        .en (en),
        .gnt(gnt),
        .idx(idx)
    );
    assign req_ready = gnt;
    assign rsp_valid = (state_q == RESP) ? (N_REQ'(1) << win_q) : '0;
    assign rsp_sum = sum_q;
    assign busy = (state_q != IDLE);
    always_comb begin
        state_d = (state_q == IDLE && |gnt) ? CALC :
                  (state_q == CALC) ? RESP :
                  (state_q == RESP && !rsp_ready[win_q]) ? RESP : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= IW'(N_REQ - 1);
            win_q <= '0;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
        end else begin
            state_q <= state_d;
            if (|gnt) begin
                ptr_q <= idx;
                win_q <= idx;
                a_q <= req_a[idx*W +: W];
                b_q <= req_b[idx*W +: W];
            end
            if (state_q == CALC) sum_q <= (W+1)'(zext_sum(MAX_W'(a_q), MAX_W'(b_q)));
        end
    end
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed checks of grant order, sums, backpressure, reset and withdrawal.
module tb_adder_share_arb;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic [W:0] rsp_sum;
    logic busy;
    int n_chk = 0, n_fail = 0;

    adder_share_arb #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lands 1 time unit after a falling edge, well clear of the next rising edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic txn(input int i, input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp, input string tag);
        step();
        req_valid[i] = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        #1 chk({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
        chk({tag, "_idle"}, 32'(busy), 0);
        step();
        req_valid[i] = 1'b0;
        chk({tag, "_calc_busy"}, 32'(busy), 1);
        chk({tag, "_calc_rsp"}, 32'(rsp_valid), 0);
        step();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << i));
        chk({tag, "_sum"}, 32'(rsp_sum), 32'(exp));
        rsp_ready[i] = 1'b1;
        step();
        rsp_ready[i] = 1'b0;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_done_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int grants, last_cyc, exp_win;
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_busy", 32'(busy), 0);
        step();
        rst = 1'b0;

        // Single request with one extra RESP cycle of backpressure.
        step();
        req_valid = 4'b0100;
        req_a[2*W +: W] = 8'd3;
        req_b[2*W +: W] = 8'd5;
        #1 chk("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        chk("single_busy1", 32'(busy), 1);
        step();
        chk("single_busy2", 32'(busy), 1);
        chk("single_rsp", 32'(rsp_valid), 32'h4);
        chk("single_sum", 32'(rsp_sum), 32'd8);
        step();
        chk("single_busy3", 32'(busy), 1);
        chk("single_hold", 32'(rsp_valid), 32'h4);
        rsp_ready = 4'b0100;
        step();
        rsp_ready = '0;
        chk("single_end_busy", 32'(busy), 0);

        txn(1, 8'hFF, 8'h01, 9'h100, "carry");
        txn(3, 8'hFF, 8'hFF, 9'h1FE, "wrap");
        txn(0, 8'h80, 8'h7F, 9'h0FF, "nocarry");

        // Fairness from reset, all requesters valid, responses always accepted.
        step();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 8'(i * 16 + 1);
            req_b[i*W +: W] = 8'(i + 2);
        end
        req_valid = '1;
        rsp_ready = '1;
        step();
        rst = 1'b0;
        grants = 0;
        last_cyc = 0;
        exp_win = 0;
        for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
            if (cyc > 0) step();
            else #1;
            if (rsp_valid != 0) begin
                chk("fair_rsp_owner", 32'(rsp_valid), 32'(1 << ((exp_win + N - 1) % N)));
                chk("fair_sum", 32'(rsp_sum), 32'(((exp_win + N - 1) % N) * 17 + 3));
            end
            if (req_ready != 0) begin
                chk("fair_order", 32'(req_ready), 32'(1 << exp_win));
                if (grants > 0) chk("fair_interval", 32'(cyc - last_cyc), 3);
                last_cyc = cyc;
                grants++;
                exp_win = (exp_win + 1) % N;
            end
        end
        chk("fair_grants", 32'(grants), 8);
        req_valid = '0;
        for (int k = 0; k < 10 && busy; k++) step();
        chk("fair_drain", 32'(busy), 0);
        rsp_ready = '0;

        // Backpressure on requester 1 with a competing request from 0.
        step();
        req_valid = 4'b0010;
        req_a[1*W +: W] = 8'd10;
        req_b[1*W +: W] = 8'd20;
        #1 chk("bp_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0001;
        req_a[0 +: W] = 8'd7;
        req_b[0 +: W] = 8'd7;
        step();
        rsp_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", 32'(rsp_valid), 32'h2);
            chk("bp_sum", 32'(rsp_sum), 32'd30);
            chk("bp_nogrant", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        rsp_ready = 4'b0010;
        step();
        rsp_ready = 4'b0000;
        chk("bp_released", 32'(rsp_valid), 0);
        chk("bp_next_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        chk("bp_r0_valid", 32'(rsp_valid), 32'h1);
        chk("bp_r0_sum", 32'(rsp_sum), 32'd14);

        // Reset while requester 0 sits in RESP; ptr would otherwise favour requester 1.
        #2 rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(rsp_valid), 0);
        chk("rstmid_sum", 32'(rsp_sum), 0);
        chk("rstmid_busy", 32'(busy), 0);
        req_valid = 4'b0011;
        #1 chk("rstmid_ready", 32'(req_ready), 0);
        step();
        step();
        rst = 1'b0;
        #1 chk("rstmid_first", 32'(req_ready), 32'h1);
        chk("rstmid_stale", 32'(rsp_valid), 0);
        step();
        req_valid = '0;
        step();
        chk("rstmid_new_rsp", 32'(rsp_valid), 32'h1);
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;

        // Requester 3 pulses valid for one cycle while busy.
        req_valid = 4'b0001;
        #1 chk("wd_ready0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
        for (int k = 0; k < 5; k++) begin
            chk("wd_nogrant", 32'(req_ready), 0);
            chk("wd_norsp", 32'(rsp_valid), 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
